// File: rtl/alu_serial_pkg.sv
// Shared types for the digit-serial add/subtract unit.
// Holds the operation and sequencer encodings plus small decode helpers.
// No logic of its own; imported by the datapath and the digit slice.
package alu_serial_pkg;

   typedef enum logic [2:0] {
      ADD = 3'd0,
      ADC = 3'd1,
      SUB = 3'd2,
      SBC = 3'd3,
      CP  = 3'd4
   } op_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Unused encodings 5..7 fold onto ADD
   function automatic op_t decode_op(input logic [2:0] raw);
      op_t o;
      case (raw)
         3'd1:    o = ADC;
         3'd2:    o = SUB;
         3'd3:    o = SBC;
         3'd4:    o = CP;
         default: o = ADD;
      endcase
      return o;
   endfunction

   // Subtract-class ops invert b and expose borrow instead of carry
   function automatic logic is_sub(input op_t o);
      return (o == SUB) || (o == SBC) || (o == CP);
   endfunction

endpackage

// File: rtl/alu_digit.sv
// One DIGIT-bit adder slice; optionally complements b for subtraction.
// Purely combinational, zero latency.
// No flow control; the sequencer decides when the slice output is used.
module alu_digit #(
   parameter int DIGIT = 4
) (
   input  logic [DIGIT-1:0] a_d,
   input  logic [DIGIT-1:0] b_d,
   input  logic             ci,
   input  logic             sub,
   output logic [DIGIT-1:0] s,
   output logic             co
);

   logic [DIGIT-1:0] bx;
   logic [DIGIT:0]   sum;

   // Add a + (b or ~b) + carry-in at DIGIT+1 bits so the carry falls out on top
   always_comb begin
      bx  = sub ? ~b_d : b_d;
      sum = {1'b0, a_d} + {1'b0, bx} + {{DIGIT{1'b0}}, ci};
   end

   assign s  = sum[DIGIT-1:0];
   assign co = sum[DIGIT];

endmodule

// File: rtl/alu_serial_addsub.sv
// Digit-serial add/sub/compare: one DIGIT slice per clock, LSD first.
// Latency N+1 cycles from the accepting edge to done; one op per N+2 cycles.
// No queueing: start is only honoured while idle; results/flags change only on the done edge.
module alu_serial_addsub
   import alu_serial_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DIGIT = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             carry,
   output logic             halfcarry,
   output logic             zero
);

   localparam int N  = WIDTH / DIGIT;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] K_LAST = CW'(N - 1);

   state_t           state;
   logic [CW-1:0]    k;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] res_sr;
   op_t              op_q;
   logic             ci;
   logic             hc_q;
   logic             z_acc;

   logic [DIGIT-1:0] dig_s;
   logic             dig_co;
   logic             sub;
   logic             z_next;
   logic [WIDTH-1:0] res_next;
   op_t              op_dec;

   assign sub    = is_sub(op_q);
   assign op_dec = decode_op(op);

   alu_digit #(.DIGIT(DIGIT)) u_digit (
      .a_d (a_sr[DIGIT-1:0]),
      .b_d (b_sr[DIGIT-1:0]),
      .ci  (ci),
      .sub (sub),
      .s   (dig_s),
      .co  (dig_co)
   );

   // Next-state views of the zero accumulator and result shifter for the current digit
   always_comb begin
      z_next   = ((k == '0) ? 1'b1 : z_acc) & (dig_s == '0);
      res_next = {dig_s, res_sr[WIDTH-1:DIGIT]};
   end

   // Sequencer, operand/result shifters and flag registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         k         <= '0;
         a_sr      <= '0;
         b_sr      <= '0;
         res_sr    <= '0;
         op_q      <= ADD;
         ci        <= 1'b0;
         hc_q      <= 1'b0;
         z_acc     <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         result    <= '0;
         carry     <= 1'b0;
         halfcarry <= 1'b0;
         zero      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state <= RUN;
                  busy  <= 1'b1;
                  k     <= '0;
                  a_sr  <= a;
                  b_sr  <= b;
                  op_q  <= op_dec;
                  // Subtraction is a + ~b + 1, so borrow-in maps to an inverted carry-in
                  case (op_dec)
                     ADC:     ci <= cin;
                     SUB:     ci <= 1'b1;
                     CP:      ci <= 1'b1;
                     SBC:     ci <= ~cin;
                     default: ci <= 1'b0;
                  endcase
               end
            end
            RUN: begin
               a_sr   <= a_sr >> DIGIT;
               b_sr   <= b_sr >> DIGIT;
               res_sr <= res_next;
               ci     <= dig_co;
               z_acc  <= z_next;
               if (k == '0) begin
                  hc_q <= dig_co;
               end
               if (k == K_LAST) begin
                  state     <= DONE;
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  carry     <= dig_co ^ sub;
                  halfcarry <= hc_q ^ sub;
                  zero      <= z_next;
                  // Compare sets flags only; the visible result keeps the last real answer
                  if (op_q != CP) begin
                     result <= res_next;
                  end
               end else begin
                  k <= k + 1'b1;
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_serial_addsub.sv
// Directed bench for alu_serial_addsub: an 8-bit table plus hand sequences
// for held start, mid-run reset and a 16-bit instance.
module tb_alu_serial_addsub;

   logic        clk;
   logic        reset_n;
   logic        start8;
   logic        start16;
   logic [2:0]  op;
   logic        cin;
   logic [7:0]  a8, b8;
   logic [15:0] a16, b16;

   logic        busy8, done8, carry8, hc8, zero8;
   logic [7:0]  result8;
   logic        busy16, done16, carry16, hc16, zero16;
   logic [15:0] result16;

   int checks = 0;
   int failures = 0;

   alu_serial_addsub #(.WIDTH(8), .DIGIT(4)) dut8 (
      .clk(clk), .reset_n(reset_n), .start(start8), .op(op),
      .a(a8), .b(b8), .cin(cin),
      .busy(busy8), .done(done8), .result(result8),
      .carry(carry8), .halfcarry(hc8), .zero(zero8)
   );

   alu_serial_addsub #(.WIDTH(16), .DIGIT(4)) dut16 (
      .clk(clk), .reset_n(reset_n), .start(start16), .op(op),
      .a(a16), .b(b16), .cin(cin),
      .busy(busy16), .done(done16), .result(result16),
      .carry(carry16), .halfcarry(hc16), .zero(zero16)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string      name;
      logic [2:0] op;
      logic [7:0] a;
      logic [7:0] b;
      logic       cin;
      logic [7:0] res;
      logic       c;
      logic       hc;
      logic       z;
   } vec_t;

   vec_t vecs[8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Launch one 8-bit op; returns the cycle index of done (accept edge = 0) and busy cycles seen
   task automatic run8(input logic [2:0] o, input logic [7:0] aa, input logic [7:0] bb,
                       input logic c, output int lat, output int bcnt);
      op = o; a8 = aa; b8 = bb; cin = c; start8 = 1'b1;
      @(posedge clk); #1;
      start8 = 1'b0;
      // scramble inputs after acceptance; they must not matter
      a8 = ~aa; b8 = ~bb; cin = ~c; op = 3'd2;
      lat = 1; bcnt = 0;
      while (!done8 && lat < 20) begin
         if (busy8) bcnt++;
         @(posedge clk); #1;
         lat++;
      end
      if (!done8) begin
         failures++;
         $display("FAIL run8 timeout: done not seen within %0d cycles", lat);
      end
   endtask

   initial begin
      int lat, bcnt;

      vecs[0] = '{"sub_3c_0d", 3'd2, 8'h3C, 8'h0D, 1'b0, 8'h2F, 1'b0, 1'b1, 1'b0};
      vecs[1] = '{"add_ff_01", 3'd0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1};
      vecs[2] = '{"sbc_10_0f", 3'd3, 8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1};
      vecs[3] = '{"cp_10_20",  3'd4, 8'h10, 8'h20, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
      vecs[4] = '{"op5_add",   3'd5, 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, 1'b0};
      vecs[5] = '{"sub_00_01", 3'd2, 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b1, 1'b0};
      vecs[6] = '{"op7_add",   3'd7, 8'h0F, 8'h01, 1'b1, 8'h10, 1'b0, 1'b1, 1'b0};
      vecs[7] = '{"cp_equal",  3'd4, 8'h55, 8'h55, 1'b0, 8'h10, 1'b0, 1'b0, 1'b1};

      reset_n = 1'b0; start8 = 1'b0; start16 = 1'b0; op = 3'd0; cin = 1'b0;
      a8 = '0; b8 = '0; a16 = '0; b16 = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_busy",   {31'd0, busy8}, 32'd0);
      check("reset_done",   {31'd0, done8}, 32'd0);
      check("reset_result", {24'd0, result8}, 32'd0);
      check("reset_flags",  {29'd0, carry8, hc8, zero8}, 32'd0);
      @(negedge clk); reset_n = 1'b1;
      @(posedge clk); #1;

      // Table-driven 8-bit operations
      for (int i = 0; i < 8; i++) begin
         run8(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin, lat, bcnt);
         check({vecs[i].name, "_latency"}, lat, 3);
         check({vecs[i].name, "_busycyc"}, bcnt, 2);
         check({vecs[i].name, "_busy_in_done"}, {31'd0, busy8}, 32'd0);
         check({vecs[i].name, "_result"}, {24'd0, result8}, {24'd0, vecs[i].res});
         check({vecs[i].name, "_carry"}, {31'd0, carry8}, {31'd0, vecs[i].c});
         check({vecs[i].name, "_halfcarry"}, {31'd0, hc8}, {31'd0, vecs[i].hc});
         check({vecs[i].name, "_zero"}, {31'd0, zero8}, {31'd0, vecs[i].z});
         @(posedge clk); #1;
         check({vecs[i].name, "_done_pulse"}, {31'd0, done8}, 32'd0);
      end

      // Start held high every cycle: one op, done-cycle start ignored, next op after IDLE cycle
      op = 3'd1; a8 = 8'h0F; b8 = 8'h00; cin = 1'b1; start8 = 1'b1;
      @(posedge clk); #1;
      lat = 1;
      while (!done8 && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      check("held_latency", lat, 3);
      check("held_result", {24'd0, result8}, 32'h10);
      check("held_halfcarry", {31'd0, hc8}, 32'd1);
      @(posedge clk); #1;
      check("held_idle_busy", {30'd0, busy8, done8}, 32'd0);
      @(posedge clk); #1;
      check("held_restart_busy", {31'd0, busy8}, 32'd1);
      start8 = 1'b0;
      lat = 1;
      while (!done8 && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      check("held2_latency", lat, 3);
      check("held2_result", {24'd0, result8}, 32'h10);
      @(posedge clk); #1;

      // Reset in the second RUN cycle discards the op and clears everything at once
      op = 3'd0; a8 = 8'h01; b8 = 8'h02; cin = 1'b0; start8 = 1'b1;
      @(posedge clk); #1;
      start8 = 1'b0;
      check("rst_run1_busy", {31'd0, busy8}, 32'd1);
      @(posedge clk); #1;
      reset_n = 1'b0;
      #1;
      check("rst_busy_done", {30'd0, busy8, done8}, 32'd0);
      check("rst_result", {24'd0, result8}, 32'd0);
      check("rst_flags", {29'd0, carry8, hc8, zero8}, 32'd0);
      @(negedge clk); reset_n = 1'b1;
      @(posedge clk); #1;
      check("rst_stays_idle", {30'd0, busy8, done8}, 32'd0);
      run8(3'd0, 8'h01, 8'h02, 1'b0, lat, bcnt);
      check("post_rst_latency", lat, 3);
      check("post_rst_result", {24'd0, result8}, 32'h03);
      check("post_rst_zero", {31'd0, zero8}, 32'd0);
      @(posedge clk); #1;

      // 16-bit instance: four digits
      op = 3'd2; a16 = 16'h8000; b16 = 16'h0001; cin = 1'b0; start16 = 1'b1;
      @(posedge clk); #1;
      start16 = 1'b0;
      a16 = 16'hFFFF; b16 = 16'hFFFF;
      lat = 1; bcnt = 0;
      while (!done16 && lat < 30) begin
         if (busy16) bcnt++;
         @(posedge clk); #1;
         lat++;
      end
      check("w16_latency", lat, 5);
      check("w16_busycyc", bcnt, 4);
      check("w16_result", {16'd0, result16}, 32'h7FFF);
      check("w16_carry", {31'd0, carry16}, 32'd0);
      check("w16_halfcarry", {31'd0, hc16}, 32'd1);
      check("w16_zero", {31'd0, zero16}, 32'd0);
      @(posedge clk); #1;
      check("w16_done_pulse", {31'd0, done16}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/alu_serial_addsub.md
# alu_serial_addsub

Parametrised digit-serial add/subtract unit for the CPU ALU datapath. It takes a WIDTH-bit operand pair and processes one DIGIT-bit slice per clock, least significant digit first. The carry between digits is held in a register. The block produces the result, carry/borrow, half-carry and zero flags, and signals completion with a start/busy/done handshake. It generalises the two-cycle 8-bit nibble ALU sequence to arbitrary width, digit size and five arithmetic modes, with its own sequencer.

## Interface
- WIDTH, 8, operand/result width in bits; must be a multiple of DIGIT.
- DIGIT, 4, bits processed per cycle; N = WIDTH/DIGIT must be ≥ 2.
- clk  in  1  system clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  begin an operation; sampled only when busy=0.
- op  in  3  operation: ADD=0, ADC=1, SUB=2, SBC=3, CP=4; values 5–7 are treated as ADD.
- a  in  WIDTH  first operand; captured on the accepting edge.
- b  in  WIDTH  second operand; captured on the accepting edge.
- cin  in  1  carry/borrow flag input for ADC/SBC; captured on the accepting edge.
- busy  out  1  high while digits are being processed.
- done  out  1  one-cycle pulse; flags and result are valid from this cycle on.
- result  out  WIDTH  arithmetic result; held until the next non-CP completion.
- carry  out  1  carry out (ADD/ADC) or borrow out (SUB/SBC/CP); true polarity.
- halfcarry  out  1  carry/borrow out of digit 0.
- zero  out  1  high when the full WIDTH-bit result is 0, including for CP.

## Operation
- States:
  - IDLE: start=1 → RUN. On this edge the block latches a, b, op and cin, sets digit index k=0 and loads the internal carry ci.
  - RUN: processes digit k. When k=N-1 → DONE; otherwise k increments.
  - DONE: lasts one cycle, done=1, then → IDLE.
- Initial internal carry ci:
  - ADD: 0.
  - ADC: cin.
  - SUB/CP: 1.
  - SBC: !cin.
- Per digit: s = a_k + (sub ? ~b_k : b_k) + ci, computed at DIGIT+1 bits. The low DIGIT bits go into the result shift register; ci ← s[DIGIT].
- Flag polarity: on subtract ops the exposed carry/halfcarry are the inverted internal carries (borrow = !carry). Internally only true carries are kept.
- halfcarry is latched from the digit-0 carry-out in the first RUN cycle.
- zero is accumulated as the AND of "digit==0" across all digits.
- CP: computes the flags exactly as SUB does, but the result output register is not written.
- start while busy or in DONE: ignored; no queueing.
- Reset (any state, including mid-RUN) forces the following, and the in-flight operation is discarded:
  - state=IDLE, busy=0, done=0.
  - result=0, carry=0, halfcarry=0, zero=0.

## Timing
- Handshake: start is accepted at edge T (busy=0). busy=1 during cycles T+1 … T+N. Digit k is processed in cycle T+1+k.
- done=1 in cycle T+N+1 only, with busy=0. The outputs update on the edge entering that cycle.
- Latency from the accepting edge to done: N+1 cycles. Back-to-back throughput: one operation per N+2 cycles, with start re-asserted during the done cycle being ignored. It is legal to assert start in the first IDLE cycle after done.
- Operand changes after the accepting edge have no effect.
- Outputs are stable outside the update edge.

## Structure
- Package alu_serial_pkg: the op_t enum (ADD, ADC, SUB, SBC, CP), the state_t enum (IDLE, RUN, DONE) and the function is_sub(op_t).
- Sub-module alu_digit: combinational DIGIT-bit slice. Inputs a_d, b_d, ci, sub; outputs s[DIGIT-1:0], co.
- The top level holds:
  - the FSM and a digit counter of width $clog2(N);
  - operand shift registers (shift right by DIGIT per RUN cycle);
  - the result shift register, filled from the MSB end;
  - the flag registers.

## Test plan
- SUB, WIDTH=8, a=0x3C, b=0x0D → result=0x2F, carry=0, halfcarry=1, zero=0. done exactly 3 cycles after the accepting edge.
- ADD, a=0xFF, b=0x01 → result=0x00, carry=1, halfcarry=1, zero=1.
- SBC, a=0x10, b=0x0F, cin=1 → result=0x00, carry=0, halfcarry=1, zero=1. Then CP with a=0x10, b=0x20 → carry=1, halfcarry=0, zero=0, result still 0x00.
- WIDTH=16, DIGIT=4: SUB a=0x8000, b=0x0001 → result=0x7FFF, carry=0, halfcarry=1. busy high for 4 cycles, done in cycle 5.
- Assert start every cycle during an ADC 0x0F+0x00, cin=1 → only one operation runs; result=0x10, halfcarry=1. The next operation starts only after done drops.
- Drop reset_n during the second RUN cycle → all outputs 0 and state IDLE immediately. After release, a fresh ADD 0x01+0x02 → 0x03, zero=0.
